// File: rtl/nivel_agua_ctrl.sv
// Water tank level controller: synchronized, debounced float sensors, level FSM with
// fault handling and fill-valve hysteresis. Define NIVEL_TIMEOUT_EN to add a fill timeout.
module nivel_agua_ctrl #(
    parameter int DEB_CYCLES   = 16,
    parameter int ERR_CYCLES   = 8,
    parameter int FILL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_alto,
    input  logic       s_medio,
    input  logic       s_baixo,
    input  logic       ack,
    output logic       A,
    output logic       M,
    output logic       B,
    output logic       alarm,
    output logic       valve,
    output logic [2:0] state_dbg
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int IW = $clog2(DEB_CYCLES + 3);
    localparam int EW = $clog2(ERR_CYCLES + 1);

    typedef enum logic [2:0] {
        INICIO = 3'd0,
        VAZIO  = 3'd1,
        BAIXO  = 3'd2,
        MEDIO  = 3'd3,
        CHEIO  = 3'd4,
        FALHA  = 3'd5
    } state_t;

    state_t        state;
    logic [2:0]    sync1, sync2, acc;
    logic [DW-1:0] deb_cnt [3];
    logic [IW-1:0] init_cnt;
    logic          init_done;
    logic [EW-1:0] err_cnt;
    logic          pat_valid, in_level, far_jump, to_hit;
    logic [1:0]    pat_lvl, cur_lvl;

    assign state_dbg = state;
    // Two sync stages plus one full debounce window before the accepted pattern is trusted.
    assign init_done = (init_cnt == IW'(DEB_CYCLES + 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 3'b000;
            sync2    <= 3'b000;
            acc      <= 3'b000;
            init_cnt <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {s_alto, s_medio, s_baixo};
            sync2 <= sync1;
            if (!init_done) init_cnt <= init_cnt + 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    acc[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pat_valid = 1'b1;
        pat_lvl   = 2'd0;
        case (acc)
            3'b000:  pat_lvl = 2'd0;
            3'b001:  pat_lvl = 2'd1;
            3'b011:  pat_lvl = 2'd2;
            3'b111:  pat_lvl = 2'd3;
            default: pat_valid = 1'b0;
        endcase
        in_level = 1'b1;
        cur_lvl  = 2'd0;
        case (state)
            VAZIO:   cur_lvl = 2'd0;
            BAIXO:   cur_lvl = 2'd1;
            MEDIO:   cur_lvl = 2'd2;
            CHEIO:   cur_lvl = 2'd3;
            default: in_level = 1'b0;
        endcase
        if (pat_lvl > cur_lvl) far_jump = (pat_lvl - cur_lvl) > 2'd1;
        else                   far_jump = (cur_lvl - pat_lvl) > 2'd1;
    end

`ifdef NIVEL_TIMEOUT_EN
    localparam int TW = $clog2(FILL_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          going_up, to_full;

    assign going_up = in_level && pat_valid && ({1'b0, pat_lvl} == {1'b0, cur_lvl} + 3'd1);
    assign to_full  = valve && (to_cnt == TW'(FILL_TIMEOUT - 1));
    // A rising level in the same cycle proves the tank is filling, so it wins over the timeout.
    assign to_hit   = to_full && !going_up && in_level;

    always_ff @(posedge clk) begin
        if (reset || !valve || going_up || to_full) to_cnt <= '0;
        else                                        to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    function automatic state_t lvl_state(input logic [1:0] l);
        case (l)
            2'd0:    return VAZIO;
            2'd1:    return BAIXO;
            2'd2:    return MEDIO;
            default: return CHEIO;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INICIO;
            err_cnt <= '0;
            A       <= 1'b0;
            M       <= 1'b0;
            B       <= 1'b0;
            alarm   <= 1'b0;
            valve   <= 1'b0;
        end else begin
            alarm <= (state == FALHA);
            case (state)
                VAZIO:   begin {A, M, B} <= 3'b000; valve <= 1'b1; end
                BAIXO:   begin {A, M, B} <= 3'b001; valve <= 1'b1; end
                MEDIO:   {A, M, B} <= 3'b011;
                CHEIO:   begin {A, M, B} <= 3'b111; valve <= 1'b0; end
                default: begin {A, M, B} <= 3'b000; valve <= 1'b0; end
            endcase

            case (state)
                INICIO: begin
                    err_cnt <= '0;
                    if (init_done) state <= pat_valid ? lvl_state(pat_lvl) : FALHA;
                end
                FALHA: begin
                    err_cnt <= '0;
                    if (ack && pat_valid) state <= lvl_state(pat_lvl);
                end
                default: begin
                    if (!pat_valid) begin
                        if (err_cnt == EW'(ERR_CYCLES - 1)) begin
                            state   <= FALHA;
                            err_cnt <= '0;
                        end else begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        err_cnt <= '0;
                        state   <= far_jump ? FALHA : lvl_state(pat_lvl);
                    end
                    if (to_hit) state <= FALHA;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nivel_agua_ctrl.sv
// Bench for nivel_agua_ctrl: level-based reference model feeding an expected queue,
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_nivel_agua_ctrl;
    localparam int DEB   = 4;
    localparam int ERR   = 3;
    localparam int TMO   = 20;
    localparam int S_INI = -1;
    localparam int S_FAL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_alto = 1'b0, s_medio = 1'b0, s_baixo = 1'b0, ack = 1'b0;
    logic       A, M, B, alarm, valve;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    nivel_agua_ctrl #(
        .DEB_CYCLES(DEB),
        .ERR_CYCLES(ERR),
        .FILL_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_alto(s_alto), .s_medio(s_medio), .s_baixo(s_baixo), .ack(ack),
        .A(A), .M(M), .B(B), .alarm(alarm), .valve(valve),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    // Levels are 0..3 (pattern = 2^level - 1), S_INI / S_FAL otherwise.
    logic [2:0] hist[$];
    logic [2:0] m_acc, m_amb, n_amb, n_acc, w;
    logic       m_alarm, m_valve, n_alarm, n_valve, all0, all1, pv, up;
    logic       started = 1'b0;
    int         m_st, m_err, m_run, m_edges, n_st, pl;

    function automatic logic is_valid(input logic [2:0] p);
        logic [2:0] q;
        q = p + 3'd1;
        return (p & q) == 3'd0;
    endfunction

    function automatic logic [2:0] lvl_pat(input int l);
        return 3'((1 << l) - 1);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i <= DEB; i++) hist.push_back(3'b000);
            m_acc = 3'b000; m_st = S_INI; m_err = 0; m_run = 0; m_edges = 0;
            m_amb = 3'b000; m_alarm = 1'b0; m_valve = 1'b0;
            started = 1'b1;
            exp_q.push_back(5'b00000);
        end else if (started) begin
            n_amb   = (m_st >= 0 && m_st <= 3) ? lvl_pat(m_st) : 3'b000;
            n_alarm = (m_st == S_FAL);
            if (m_st == 0 || m_st == 1) n_valve = 1'b1;
            else if (m_st == 2)         n_valve = m_valve;
            else                        n_valve = 1'b0;

            n_st = m_st; up = 1'b0;
            pv = is_valid(m_acc);
            pl = $countones(m_acc);
            if (m_st == S_INI) begin
                m_err = 0;
                if (m_edges >= DEB + 2) n_st = pv ? pl : S_FAL;
            end else if (m_st == S_FAL) begin
                m_err = 0;
                if (ack && pv) n_st = pl;
            end else if (!pv) begin
                m_err++;
                if (m_err == ERR) begin n_st = S_FAL; m_err = 0; end
            end else begin
                m_err = 0;
                n_st = (pl - m_st > 1 || m_st - pl > 1) ? S_FAL : pl;
                up = (pl == m_st + 1);
            end
`ifdef NIVEL_TIMEOUT_EN
            if (!m_valve || up) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == TMO) begin
                    m_run = 0;
                    if (m_st >= 0 && m_st <= 3) n_st = S_FAL;
                end
            end
`endif
            // a sensor is accepted once its last DEB synchronized samples all agree
            for (int b = 0; b < 3; b++) begin
                all0 = 1'b1; all1 = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    w = hist[k];
                    if (w[b]) all0 = 1'b0; else all1 = 1'b0;
                end
                n_acc[b] = all1 ? 1'b1 : (all0 ? 1'b0 : m_acc[b]);
            end
            hist.push_back({s_alto, s_medio, s_baixo});
            void'(hist.pop_front());
            m_edges++;

            m_amb = n_amb; m_alarm = n_alarm; m_valve = n_valve;
            m_st = n_st; m_acc = n_acc;
            exp_q.push_back({m_amb, m_alarm, m_valve});
        end
    end

    // ---------------- scoreboard ----------------
    logic [4:0] exp_w;
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_empty at %0t: got no expected entry, expected one", $time);
            end else begin
                exp_w = exp_q.pop_front();
                check("sb_amb",   {A, M, B}, exp_w[4:2]);
                check("sb_alarm", {2'b00, alarm}, {2'b00, exp_w[1]});
                check("sb_valve", {2'b00, valve}, {2'b00, exp_w[0]});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [2:0] p);
        {s_alto, s_medio, s_baixo} = p;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        reset = 1'b1; set_raw(3'b000); ack = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_amb", {A, M, B}, 3'b000);
        check("rst_alarm", {2'b00, alarm}, 3'd0);
        check("rst_valve", {2'b00, valve}, 3'd0);
        tick(7);
        check("init_valve_early", {2'b00, valve}, 3'd0);
        tick(1);
        check("vazio_valve", {2'b00, valve}, 3'd1);
        check("vazio_amb", {A, M, B}, 3'b000);
        check("vazio_alarm", {2'b00, alarm}, 3'd0);

        // climb one level at a time
        set_raw(3'b001); tick(7);
        check("baixo_pre", {A, M, B}, 3'b000);
        tick(1);
        check("baixo_amb", {A, M, B}, 3'b001);
        check("baixo_valve", {2'b00, valve}, 3'd1);
        tick(2);
        set_raw(3'b011); tick(7);
        check("medio_pre", {A, M, B}, 3'b001);
        tick(1);
        check("medio_amb", {A, M, B}, 3'b011);
        check("medio_valve", {2'b00, valve}, 3'd1);
        tick(2);
        set_raw(3'b111); tick(7);
        check("cheio_pre_valve", {2'b00, valve}, 3'd1);
        tick(1);
        check("cheio_amb", {A, M, B}, 3'b111);
        check("cheio_valve", {2'b00, valve}, 3'd0);
        tick(2);
        set_raw(3'b011); tick(8);
        check("medio_down_amb", {A, M, B}, 3'b011);
        check("medio_down_valve", {2'b00, valve}, 3'd0);

        // bouncing low sensor never accepted
        for (int i = 0; i < 10; i++) begin
            s_baixo = ~s_baixo;
            tick(2);
        end
        tick(8);
        check("bounce_amb", {A, M, B}, 3'b011);
        check("bounce_alarm", {2'b00, alarm}, 3'd0);

        // invalid pattern persisting -> fault; ack ignored until pattern valid
        set_raw(3'b100); tick(9);
        check("inv_pre_alarm", {2'b00, alarm}, 3'd0);
        check("inv_pre_amb", {A, M, B}, 3'b011);
        tick(1);
        check("inv_alarm", {2'b00, alarm}, 3'd1);
        check("inv_amb", {A, M, B}, 3'b000);
        check("inv_valve", {2'b00, valve}, 3'd0);
        tick(2);
        pulse_ack();
        tick(2);
        check("ack_invalid_alarm", {2'b00, alarm}, 3'd1);
        set_raw(3'b011); tick(7);
        pulse_ack();
        check("ack_edge_alarm", {2'b00, alarm}, 3'd1);
        tick(1);
        check("ack_ok_alarm", {2'b00, alarm}, 3'd0);
        check("ack_ok_amb", {A, M, B}, 3'b011);
        check("ack_ok_valve", {2'b00, valve}, 3'd0);

        // two-level jump from BAIXO
        set_raw(3'b001); tick(8);
        check("baixo2_amb", {A, M, B}, 3'b001);
        check("baixo2_valve", {2'b00, valve}, 3'd1);
        tick(2);
        set_raw(3'b111); tick(7);
        check("jump_pre_alarm", {2'b00, alarm}, 3'd0);
        check("jump_pre_amb", {A, M, B}, 3'b001);
        tick(1);
        check("jump_alarm", {2'b00, alarm}, 3'd1);
        check("jump_amb", {A, M, B}, 3'b000);

        // recover into BAIXO and hold: fill timeout only when enabled
        set_raw(3'b001); tick(7);
        pulse_ack();
        tick(1);
        check("fill_valve", {2'b00, valve}, 3'd1);
        check("fill_alarm", {2'b00, alarm}, 3'd0);
        tick(20);
        check("fill_pre_alarm", {2'b00, alarm}, 3'd0);
        tick(1);
`ifdef NIVEL_TIMEOUT_EN
        check("timeout_alarm", {2'b00, alarm}, 3'd1);
`else
        check("no_timeout_alarm", {2'b00, alarm}, 3'd0);
`endif
        pulse_ack();
        tick(2);

        // reset mid-debounce
        set_raw(3'b011); tick(3);
        reset = 1'b1; tick(1);
        check("rst_mid_amb", {A, M, B}, 3'b000);
        check("rst_mid_alarm", {2'b00, alarm}, 3'd0);
        check("rst_mid_valve", {2'b00, valve}, 3'd0);
        tick(2);

        // invalid pattern at start-up goes straight to fault; reset overrides fault
        set_raw(3'b100); reset = 1'b0; tick(7);
        check("init_inv_pre", {2'b00, alarm}, 3'd0);
        tick(1);
        check("init_inv_alarm", {2'b00, alarm}, 3'd1);
        reset = 1'b1; tick(1);
        check("rst_falha_alarm", {2'b00, alarm}, 3'd0);
        tick(2);
        set_raw(3'b000); reset = 1'b0; tick(8);
        check("reinit_valve", {2'b00, valve}, 3'd1);
        check("reinit_alarm", {2'b00, alarm}, 3'd0);
        tick(3);

        report();
        $finish;
    end

    initial begin
        #200000;
        n_cmp++; n_err++;
        $display("FAIL watchdog at %0t: got no end of stimulus, expected finish", $time);
        report();
        $finish;
    end
endmodule
